// File: rtl/fc_layer_seq.sv
// Time-multiplexed fully-connected layer: PAR_OUT MAC lanes sweep the inputs, then a bias/requantise/ReLU6 stage.
// Build option: define FC_ROUND_NEAREST_EN to round half up before the requantising shift (default truncates).
module fc_layer_seq #(
    parameter int DATA_WIDTH          = 16,
    parameter int FRAC_BITS           = 7,
    parameter int INPUT_NEURON_COUNT  = 15,
    parameter int OUTPUT_NEURON_COUNT = 15,
    parameter int PAR_OUT             = 5,
    parameter int RELU_THRESHOLD      = 6,
    localparam int ADDR_W = $clog2(OUTPUT_NEURON_COUNT*INPUT_NEURON_COUNT + OUTPUT_NEURON_COUNT)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      cfg_we,
    input  logic [ADDR_W-1:0]                         cfg_addr,
    input  logic [DATA_WIDTH-1:0]                     cfg_data,
    output logic                                      cfg_err,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [INPUT_NEURON_COUNT*DATA_WIDTH-1:0]  in_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [OUTPUT_NEURON_COUNT*DATA_WIDTH-1:0] out_data,
    output logic                                      busy
);
    localparam int IN     = INPUT_NEURON_COUNT;
    localparam int OUT    = OUTPUT_NEURON_COUNT;
    localparam int G      = OUT / PAR_OUT;
    localparam int NW     = OUT*IN + OUT;
    localparam int ACC_W  = 2*DATA_WIDTH + $clog2(IN+1);
    localparam int I_W    = (IN > 1) ? $clog2(IN) : 1;
    localparam int G_W    = (G > 1) ? $clog2(G) : 1;
`ifdef FC_ROUND_NEAREST_EN
    localparam int RND_I  = 2**(FRAC_BITS-1);
`else
    localparam int RND_I  = 0;
`endif
    localparam logic signed [ACC_W-1:0] RND_C  = ACC_W'(RND_I);
    localparam logic signed [ACC_W-1:0] CEIL_C = ACC_W'(RELU_THRESHOLD * (2**FRAC_BITS));
    localparam logic signed [ACC_W-1:0] DMAX_C = ACC_W'((2**(DATA_WIDTH-1)) - 1);
    localparam bit CEIL_EN = (RELU_THRESHOLD != 0);

    generate
        if (OUT % PAR_OUT != 0) begin : g_bad_par_out
            $error("fc_layer_seq: OUTPUT_NEURON_COUNT must be a multiple of PAR_OUT");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_ACT  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t                        state_r;
    logic [I_W-1:0]                i_r;
    logic [G_W-1:0]                g_r;
    logic signed [DATA_WIDTH-1:0]  wb_r  [NW];
    logic signed [DATA_WIDTH-1:0]  x_r   [IN];
    logic signed [ACC_W-1:0]       acc_r [PAR_OUT];
    logic [OUT*DATA_WIDTH-1:0]     out_data_r;
    logic                          out_valid_r;
    logic                          in_ready_r;
    logic                          busy_r;
    logic                          cfg_err_r;
    logic                          cfg_ok_s;

    logic signed [DATA_WIDTH-1:0]   w_sel_s [PAR_OUT];
    logic signed [DATA_WIDTH-1:0]   b_sel_s [PAR_OUT];
    logic signed [2*DATA_WIDTH-1:0] mul_s   [PAR_OUT];
    logic signed [ACC_W-1:0]        q_s     [PAR_OUT];
    logic signed [DATA_WIDTH-1:0]   act_s   [PAR_OUT];

    // Writes are only taken while idle so a running vector never sees a half-updated weight set.
    assign cfg_ok_s = cfg_we && !busy_r && ({1'b0, cfg_addr} < (ADDR_W+1)'(NW));

    // Weight/bias storage: deliberately not reset so coefficients survive a reset.
    always_ff @(posedge clk) begin
        if (cfg_ok_s) begin
            wb_r[cfg_addr] <= cfg_data;
        end
    end

    // Config error pulse for any dropped write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= cfg_we && !cfg_ok_s;
        end
    end

    // Per-lane operand select, product, and bias/requantise/clamp of the accumulator.
    always_comb begin
        for (int k = 0; k < PAR_OUT; k++) begin
            w_sel_s[k] = wb_r[ADDR_W'((int'(g_r)*PAR_OUT + k)*IN + int'(i_r))];
            b_sel_s[k] = wb_r[ADDR_W'(OUT*IN + int'(g_r)*PAR_OUT + k)];
            mul_s[k]   = (2*DATA_WIDTH)'(x_r[i_r]) * (2*DATA_WIDTH)'(w_sel_s[k]);
            q_s[k]     = (acc_r[k] + (ACC_W'(b_sel_s[k]) <<< FRAC_BITS) + RND_C) >>> FRAC_BITS;
            if (q_s[k][ACC_W-1]) begin
                act_s[k] = {DATA_WIDTH{1'b0}};
            end else if (CEIL_EN && (q_s[k] > CEIL_C)) begin
                act_s[k] = CEIL_C[DATA_WIDTH-1:0];
            end else if (q_s[k] > DMAX_C) begin
                act_s[k] = DMAX_C[DATA_WIDTH-1:0];
            end else begin
                act_s[k] = q_s[k][DATA_WIDTH-1:0];
            end
        end
    end

    // Control FSM with all handshake/status outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            i_r         <= {I_W{1'b0}};
            g_r         <= {G_W{1'b0}};
            out_data_r  <= {(OUT*DATA_WIDTH){1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            for (int i = 0; i < IN; i++) begin
                x_r[i] <= {DATA_WIDTH{1'b0}};
            end
            for (int k = 0; k < PAR_OUT; k++) begin
                acc_r[k] <= {ACC_W{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        for (int i = 0; i < IN; i++) begin
                            x_r[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        for (int k = 0; k < PAR_OUT; k++) begin
                            acc_r[k] <= {ACC_W{1'b0}};
                        end
                        i_r        <= {I_W{1'b0}};
                        g_r        <= {G_W{1'b0}};
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    for (int k = 0; k < PAR_OUT; k++) begin
                        acc_r[k] <= acc_r[k] + ACC_W'(mul_s[k]);
                    end
                    if (i_r == I_W'(IN-1)) begin
                        state_r <= ST_ACT;
                    end else begin
                        i_r <= i_r + I_W'(1);
                    end
                end
                ST_ACT: begin
                    for (int k = 0; k < PAR_OUT; k++) begin
                        out_data_r[(int'(g_r)*PAR_OUT + k)*DATA_WIDTH +: DATA_WIDTH] <= act_s[k];
                        acc_r[k] <= {ACC_W{1'b0}};
                    end
                    i_r <= {I_W{1'b0}};
                    if (g_r == G_W'(G-1)) begin
                        out_valid_r <= 1'b1;
                        state_r     <= ST_OUT;
                    end else begin
                        g_r     <= g_r + G_W'(1);
                        state_r <= ST_MAC;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_err   = cfg_err_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;

endmodule

// File: doc/fc_layer_seq.md
Name: fc_layer_seq

Overview:
Time-multiplexed, parametrised fully-connected layer with ReLU6-style clamp on the output. It replaces the fully-combinational all-neurons-at-once FC datapath with PAR_OUT MAC lanes that iterate over inputs, trading latency for area. Weights and biases sit in internal registers loaded through a config write port. Input vectors and output vectors move over valid/ready handshakes so layers can be chained in the pipelined DNN.

Parameters:
DATA_WIDTH, 16, signed fixed-point word width of inputs, weights, biases and outputs
FRAC_BITS, 7, fraction bits of every DATA_WIDTH word (Q8.7 default)
INPUT_NEURON_COUNT, 15, inputs per vector (IN)
OUTPUT_NEURON_COUNT, 15, output neurons (OUT)
PAR_OUT, 5, parallel MAC lanes; OUT % PAR_OUT must be 0 (elaboration error otherwise)
RELU_THRESHOLD, 6, integer clamp ceiling; 0 disables the ceiling (plain ReLU)

Ports:
clk  in  1  single clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  config write strobe
cfg_addr  in  clog2(OUT*IN+OUT)  0..OUT*IN-1 = weight[j][i] at j*IN+i; OUT*IN+j = bias[j]
cfg_data  in  DATA_WIDTH  weight/bias value
cfg_err  out  1  one-cycle pulse: write dropped (busy or addr out of range)
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector
in_data  in  IN*DATA_WIDTH  input vector, element i at [i*DATA_WIDTH +: DATA_WIDTH]
out_valid  out  1  output vector valid
out_ready  in  1  downstream accepts
out_data  out  OUT*DATA_WIDTH  output vector, same packing
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1, out_valid=0, busy=0, cfg_err=0, out_data=0, counters 0. Weight/bias registers are not reset.
- FSM: IDLE -> MAC on in_valid&in_ready (in_data latched). MAC: each cycle lane k does acc[k] += x[i]*w[g*PAR_OUT+k][i]; i=0..IN-1. After i=IN-1 -> ACT. ACT (1 cycle): add bias, requantise, clamp, write out_data slice for group g. If g<G-1 -> MAC with g+1, i=0, acc cleared; else -> OUT. OUT: out_valid=1 and out_data stable until out_ready; on handshake -> IDLE.
- G = OUT/PAR_OUT. Latency from input handshake to out_valid: G*(IN+1)+1 cycles. Throughput: one vector per G*(IN+1)+2 cycles with out_ready held high.
- in_ready=1 only in IDLE. No overlap of input and output vectors.
- Arithmetic: signed product 2*DATA_WIDTH bits with 2*FRAC_BITS fraction bits. Accumulator ACC_W = 2*DATA_WIDTH + clog2(IN+1); no overflow is possible. Bias is sign-extended and shifted left by FRAC_BITS before the add.
- Requantise: shift right by FRAC_BITS (truncate toward -inf by default). Then: result<0 -> 0. Result > RELU_THRESHOLD<<FRAC_BITS (when threshold != 0) -> RELU_THRESHOLD<<FRAC_BITS. Otherwise the low DATA_WIDTH bits. With threshold 0, values above the DATA_WIDTH signed max saturate to max.
- Config: a write is accepted only when busy=0 and cfg_addr is in range; otherwise it is dropped and cfg_err pulses. If cfg_we and in_valid arrive in the same IDLE cycle, the write is applied first and the MAC starts next cycle using the new value.
- Reset mid-operation: the partial vector is abandoned and no out_valid follows; weights are retained.

Optional Feature:
FC_ROUND_NEAREST_EN: defined -> requantise adds 1<<(FRAC_BITS-1) before the shift (round half up), then clamps. Undefined -> plain truncating shift. Latency is identical either way.

Test Plan:
IN=4, OUT=4, PAR_OUT=2, all weights 0x0080, biases 0, inputs 0x0080 -> out_valid 11 cycles after the input handshake; every output is 0x0200 (4.0).
Inputs 0x0100, weights 0x0080, bias[0]=0x0080 -> every output is 0x0300 (clamped 6.0); with RELU_THRESHOLD=0, output 0 is 0x0480 and the others are 0x0400.
Row 1 weights 0xFF80 (-1.0), inputs 0x0080 -> out[1]=0x0000; other rows unaffected.
out_ready low for 5 cycles while out_valid=1 -> out_data stable, in_ready=0; handshake on cycle 6, then in_ready=1 next cycle.
cfg_we during MAC with addr 0, data 0x7FFF -> cfg_err pulses once; next vector uses the old weight. Also assert rst_n low mid-MAC -> out_valid stays 0, in_ready=1 after reset release.
Single input 0x0001, weight 0x0040, others 0 -> out=0x0000 without FC_ROUND_NEAREST_EN, 0x0001 with it.
